// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side consumer of the dual-clock FIFO, in the FIFO read clock domain.
// It turns the FIFO read/empty/dout interface (dout valid one cycle after read) into a
// valid/ready stream. A 3-entry circular output buffer sustains 1 word/clk. The next read is
// chosen from registered state only, so there is no combinational m_ready -> fifo_read path.
// The stream is framed into fixed-length packets (m_last), and the block counts accepted beats
// and accepted packet ends.
//
// Ports:
//   clk        in   FIFO read-domain clock
//   rst_n      in   asynchronous active-low reset
//   en         in   1 = issue FIFO reads; 0 = no new reads, buffered words still drain
//   fifo_empty in   FIFO read-domain empty flag
//   fifo_dout  in   FIFO data, valid the cycle after fifo_read=1
//   fifo_read  out  registered FIFO read strobe
//   m_data     out  stream data (head of the buffer)
//   m_valid    out  stream valid (buffer not empty)
//   m_ready    in   stream ready; a beat transfers on an edge with m_valid & m_ready
//   m_last     out  last beat of a packet (never set when PKT_LEN = 0)
//   beat_cnt   out  accepted beats, wraps modulo 2**CW
//   pkt_cnt    out  accepted beats with m_last=1, wraps modulo 2**CW
//   occ        out  words held in the output buffer, 0..3
module fifo_stream_reader #(
  parameter int unsigned DW      = 8,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_read,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [CW-1:0] beat_cnt,
  output logic [CW-1:0] pkt_cnt,
  output logic [1:0]    occ
);

  localparam int unsigned IW        = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam bit          FramingOn = (PKT_LEN != 0);
  localparam logic [IW-1:0] LastIdx = FramingOn ? IW'(PKT_LEN - 1) : '0;

  logic          fifo_read_q, fifo_read_d;
  logic          inflight_q;
  logic [1:0]    occ_q, occ_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [3];
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          push, pop, head_last;
  logic [2:0]    fill;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    push      = inflight_q;
    head_last = FramingOn && (idx_q == LastIdx);
    pop       = (occ_q != 2'd0) && m_ready;

    occ_d    = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Words held after this edge plus the read now becoming in flight; a new read is allowed
    // only if that leaves room, so held + in flight + issued never exceeds 3.
    fill        = {1'b0, occ_d} + {2'b00, fifo_read_q};
    fifo_read_d = en && !fifo_empty && (fill < 3'd3);

    idx_d = idx_q;
    if (!FramingOn) begin
      idx_d = '0;
    end else if (pop) begin
      idx_d = head_last ? '0 : idx_q + IW'(1);
    end

    beat_cnt_d = beat_cnt_q + CW'(pop);
    pkt_cnt_d  = pkt_cnt_q + CW'(pop && head_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_read_q <= 1'b0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      idx_q       <= '0;
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fifo_read_q <= fifo_read_d;
      inflight_q  <= fifo_read_q;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= fifo_dout;
      end
    end
  end

  assign fifo_read = fifo_read_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = mem_q[rd_ptr_q];
  assign m_last    = m_valid && head_last;
  assign beat_cnt  = beat_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        stall = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;

  logic        fifo_read0, m_valid0, m_last0;
  logic [7:0]  m_data0;
  logic [31:0] beat_cnt0, pkt_cnt0;
  logic [1:0]  occ0;
  logic        fifo_read1, m_valid1, m_last1;
  logic [7:0]  m_data1;
  logic [31:0] beat_cnt1, pkt_cnt1;
  logic [1:0]  occ1;

  int checks = 0;
  int errors = 0;

  // FIFO model: source words in src[0..src_n-1], read pointer fp.
  logic [7:0] src [512];
  int src_n = 0;
  int fp = 0;
  int reads = 0;
  // Scoreboard: words handed to the DUT, in order.
  logic [7:0] exp_mem [1024];
  int wr_i = 0;
  int rd_i = 0;
  int beats = 0;
  int bidx = 0;
  logic infl = 1'b0;

  always #5 clk = ~clk;

  // Empty reflects the read strobe currently being presented, like a FIFO that updates its
  // flag as the read is accepted.
  assign fifo_empty = stall || ((src_n - fp - int'(fifo_read0)) <= 0);

  fifo_stream_reader #(.DW(8), .PKT_LEN(4), .CW(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
    .m_last(m_last0), .beat_cnt(beat_cnt0), .pkt_cnt(pkt_cnt0), .occ(occ0)
  );

  fifo_stream_reader #(.DW(8), .PKT_LEN(0), .CW(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(fifo_read1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
    .m_last(m_last1), .beat_cnt(beat_cnt1), .pkt_cnt(pkt_cnt1), .occ(occ1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model and scoreboard producer.
  always @(posedge clk) begin
    if (!rst_n) begin
      fp <= src_n;
    end else if (fifo_read0) begin
      checks++;
      if (fp >= src_n) begin
        errors++;
        $display("FAIL fifo_underflow actual=read_with_%0d_words expected=no_read", src_n - fp);
      end else begin
        fifo_dout      <= src[fp];
        exp_mem[wr_i]  <= src[fp];
        wr_i           <= wr_i + 1;
        fp             <= fp + 1;
      end
      reads <= reads + 1;
    end
  end

  // Monitor: pops and compares whenever a beat transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_i = wr_i;
      beats = 0;
      bidx = 0;
      infl = 1'b0;
    end else begin
      chk("valid_vs_occ", 64'(m_valid0), 64'(occ0 != 2'd0));
      chk("occ_bound", 64'((int'(occ0) + int'(infl) + int'(fifo_read0)) <= 3), 64'd1);
      if (m_valid0 && m_ready) begin
        if (rd_i >= wr_i) begin
          chk("beat_without_word", 64'd1, 64'd0);
        end else begin
          chk("m_data", 64'(m_data0), 64'(exp_mem[rd_i]));
          chk("m_last", 64'(m_last0), 64'(bidx == 3));
          chk("m_data_nolen", 64'(m_data1), 64'(exp_mem[rd_i]));
          chk("m_valid_nolen", 64'(m_valid1), 64'd1);
          chk("m_last_nolen", 64'(m_last1), 64'd0);
        end
        rd_i++;
        beats++;
        bidx = (bidx + 1) % 4;
      end
      infl = fifo_read0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    stall = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic load_seq(input logic [7:0] first, input int n);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      src[src_n] = v;
      src_n++;
      v = v + 8'd1;
    end
  endtask

  task automatic wait_beats(input string nm, input int target, input int budget);
    int c;
    c = 0;
    while (beats < target && c < budget) begin
      tick(1);
      c++;
    end
    chk(nm, 64'(beats), 64'(target));
  endtask

  initial begin
    int first_rd, first_v, run, r0, c;

    // 1: asynchronous reset mid-stream.
    do_reset();
    load_seq(8'h01, 12);
    en = 1'b1;
    c = 0;
    while (!(occ0 != 2'd0 && fifo_read0) && c < 20) begin
      tick(1);
      c++;
    end
    chk("t1_midstream_reached", 64'(occ0 != 2'd0 && fifo_read0), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_fifo_read", 64'(fifo_read0), 64'd0);
    chk("t1_rst_m_valid", 64'(m_valid0), 64'd0);
    chk("t1_rst_m_last", 64'(m_last0), 64'd0);
    chk("t1_rst_occ", 64'(occ0), 64'd0);
    chk("t1_rst_m_data", 64'(m_data0), 64'd0);
    chk("t1_rst_beat_cnt", 64'(beat_cnt0), 64'd0);
    chk("t1_rst_pkt_cnt", 64'(pkt_cnt0), 64'd0);
    tick(1);
    chk("t1_rst_held_read", 64'(fifo_read0), 64'd0);
    tick(1);
    rst_n = 1'b1;
    chk("t1_release_read", 64'(fifo_read0), 64'd0);

    // 2: latency, throughput and framing with PKT_LEN=4.
    do_reset();
    load_seq(8'h01, 10);
    m_ready = 1'b1;
    en = 1'b1;
    first_rd = -1;
    first_v = -1;
    run = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (first_rd < 0 && fifo_read0) first_rd = i;
      if (first_v < 0 && m_valid0) first_v = i;
      if (first_v >= 0 && m_valid0 && run == i - first_v) run++;
    end
    tick(1);
    chk("t2_first_valid_latency", 64'(first_v - first_rd), 64'd2);
    chk("t2_contiguous_beats", 64'(run), 64'd10);
    chk("t2_beats", 64'(beats), 64'd10);
    chk("t2_beat_cnt", 64'(beat_cnt0), 64'd10);
    chk("t2_pkt_cnt", 64'(pkt_cnt0), 64'd2);
    chk("t2_nolen_beat_cnt", 64'(beat_cnt1), 64'd10);
    chk("t2_nolen_pkt_cnt", 64'(pkt_cnt1), 64'd0);

    // 3: backpressure fills the buffer with exactly three reads, then drains without gaps.
    do_reset();
    load_seq(8'h01, 10);
    m_ready = 1'b0;
    en = 1'b1;
    r0 = reads;
    tick(10);
    chk("t3_read_pulses", 64'(reads - r0), 64'd3);
    chk("t3_occ_full", 64'(occ0), 64'd3);
    chk("t3_valid_held", 64'(m_valid0), 64'd1);
    chk("t3_data_held", 64'(m_data0), 64'h01);
    m_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid0 && run == i) run++;
    end
    tick(1);
    chk("t3_contiguous_beats", 64'(run), 64'd10);
    chk("t3_beat_cnt", 64'(beat_cnt0), 64'd10);

    // 4: 200 random words, random ready and empty stalls.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      src[src_n] = 8'($urandom_range(0, 255));
      src_n++;
    end
    en = 1'b1;
    c = 0;
    while (beats < 200 && c < 4000) begin
      m_ready = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      tick(1);
      c++;
    end
    m_ready = 1'b0;
    stall = 1'b0;
    chk("t4_beats", 64'(beats), 64'd200);
    chk("t4_beat_cnt", 64'(beat_cnt0), 64'd200);
    chk("t4_pkt_cnt", 64'(pkt_cnt0), 64'd50);
    chk("t4_all_delivered", 64'(rd_i == wr_i), 64'd1);

    // 5: en dropped mid-burst; words held and in flight still drain.
    do_reset();
    load_seq(8'h40, 10);
    m_ready = 1'b1;
    en = 1'b1;
    tick(5);
    chk("t5_occ_before", 64'(occ0), 64'd1);
    chk("t5_read_before", 64'(fifo_read0), 64'd1);
    en = 1'b0;
    r0 = reads;
    tick(1);
    chk("t5_read_stopped", 64'(fifo_read0), 64'd0);
    tick(4);
    chk("t5_drained_valid", 64'(m_valid0), 64'd0);
    chk("t5_last_read_taken", 64'(reads - r0), 64'd1);
    chk("t5_beats_before_resume", 64'(beats), 64'd5);
    chk("t5_all_delivered", 64'(rd_i == wr_i), 64'd1);
    en = 1'b1;
    tick(1);
    chk("t5_read_resumed", 64'(fifo_read0), 64'd1);
    wait_beats("t5_beats", 10, 100);
    chk("t5_pkt_cnt", 64'(pkt_cnt0), 64'd2);

    // 6: framing off, 20 words.
    do_reset();
    load_seq(8'h20, 20);
    m_ready = 1'b1;
    en = 1'b1;
    wait_beats("t6_beats", 20, 200);
    chk("t6_nolen_beat_cnt", 64'(beat_cnt1), 64'd20);
    chk("t6_nolen_pkt_cnt", 64'(pkt_cnt1), 64'd0);
    chk("t6_pkt_cnt_len4", 64'(pkt_cnt0), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
